// File: rtl/cpu_uart_tx.sv
// 8N1 UART transmitter with a small FIFO, draining CPU output bytes onto one pin.
// The FIFO, the divider and the frame sequencer all live in this one module.
module cpu_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RESET_B,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          clr_overflow,
  output logic          tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic wr_accept;
  logic baud_end;
  logic has_data;
  logic pop;
  logic shift_en;

  // Ready comes only from the registered count, so a same-edge pop never frees a slot early.
  assign wr_ready   = (count != FULL_CNT);
  assign fifo_count = count;
  assign wr_accept  = wr_valid && wr_ready;
  assign baud_end   = (baud == BAUD_LAST);
  assign has_data   = (count != '0);
  assign pop        = has_data && ((state == IDLE) || ((state == STOP) && baud_end));
  assign shift_en   = (state == DATA) && baud_end;

  always_ff @(posedge CLK) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
    if (pop)           shift <= mem[rd_ptr];
    else if (shift_en) shift <= {1'b0, shift[7:1]};
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      case ({wr_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_valid && !wr_ready) overflow <= 1'b1;
      else if (clr_overflow)     overflow <= 1'b0;
    end
  end

  // Frame sequencer; tx is registered and forced high on reset so an aborted frame never glitches low.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            baud  <= '0;
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
            baud    <= '0;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_uart_tx.sv
// Scoreboarded bench for cpu_uart_tx: a frame-level timing model predicts the pin,
// and a line decoder pops expected bytes from the scoreboard as frames complete.
module tb_cpu_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  logic          CLK = 1'b0;
  logic          RESET_B = 1'b1;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_overflow = 1'b0;
  logic          wr_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  always #5 CLK = ~CLK;

  cpu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_overflow(clr_overflow), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of waiting bytes plus cycles left in the frame on the line.
  byte unsigned m_fifo[$];
  byte unsigned sb_q[$];
  int           m_rem = 0;
  bit           m_ovf = 1'b0;
  logic [7:0]   m_cur = 8'h00;
  bit           m_rdy, m_acc, m_pop;

  initial forever begin
    @(posedge CLK or negedge RESET_B);
    if (!RESET_B) begin
      m_fifo.delete();
      sb_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      m_rdy = (m_fifo.size() < DEPTH);
      m_acc = wr_valid && m_rdy;
      m_pop = (m_fifo.size() != 0) && (m_rem <= 1);
      if (wr_valid && !m_rdy) m_ovf = 1'b1;
      else if (clr_overflow)  m_ovf = 1'b0;
      if (m_pop) begin
        m_cur = m_fifo.pop_front();
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (m_acc) begin
        m_fifo.push_back(wr_data);
        sb_q.push_back(wr_data);
      end
    end
  end

  function automatic logic exp_tx();
    int k, b;
    if (m_rem == 0) return 1'b1;
    k = FRAME - m_rem;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  // Cycle checker on the falling edge.
  initial forever begin
    @(negedge CLK);
    check("busy", busy, (m_rem != 0));
    check("fifo_count", fifo_count, m_fifo.size());
    check("wr_ready", wr_ready, (m_fifo.size() < DEPTH));
    check("overflow", overflow, m_ovf);
    check("tx", tx, exp_tx());
  end

  // Line decoder / scoreboard monitor.
  bit         inframe = 1'b0;
  int         mk = 0;
  logic [7:0] rx = 8'h00;

  initial forever begin
    @(negedge CLK);
    if (!RESET_B) begin
      inframe = 1'b0;
    end else if (!inframe) begin
      if (tx == 1'b0) begin
        inframe = 1'b1;
        mk = 0;
      end
    end else begin
      mk++;
      if (mk == CPB / 2) check("rx_start", tx, 1'b0);
      if ((mk % CPB == CPB / 2) && mk >= CPB && mk < 9 * CPB) rx[mk / CPB - 1] = tx;
      if (mk == 9 * CPB + CPB / 2) begin
        check("rx_stop", tx, 1'b1);
        if (sb_q.size() == 0) check("rx_unexpected", rx, 32'hFFFF_FFFF);
        else check("rx_byte", rx, sb_q.pop_front());
      end
      if (mk == FRAME - 1) inframe = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    @(negedge CLK);
    wr_valid = v;
    wr_data = d;
    clr_overflow = c;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (m_rem == 0 && m_fifo.size() == 0) break;
    end
    check("drain_in_budget", (i < budget), 1);
    repeat (2) @(negedge CLK);
  endtask

  int  cnt;
  int  t;
  bit  seen_low;
  int  gap;
  byte unsigned base;

  initial begin
    #1 RESET_B = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ready", wr_ready, 1'b1);
    RESET_B = 1'b1;
    repeat (2) @(negedge CLK);

    // Single byte, latency and frame shape
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("lat_n_tx", tx, 1'b1);
    check("lat_n_count", fifo_count, 1);
    @(negedge CLK);
    check("lat_n1_tx", tx, 1'b0);
    check("lat_n1_busy", busy, 1'b1);
    cnt = 1;
    while (busy && cnt < 200) begin
      @(negedge CLK);
      if (busy) cnt++;
    end
    check("a5_busy_len", cnt, FRAME);
    wait_drain(200);

    // Back-to-back frames with no idle gap
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hFF, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      @(negedge CLK);
    end
    check("b2b_busy_len", cnt, 2 * FRAME);
    wait_drain(200);

    // Overflow and its clear
    for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("ovf_set", overflow, 1'b1);
    check("ovf_full", fifo_count, DEPTH);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h07, 1'b1);
    check("ovf_cleared", overflow, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("ovf_set_wins", overflow, 1'b1);
    wait_drain(1000);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Reset in the middle of data bit 3 with two bytes still queued
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b1, 8'h96, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    repeat (16) @(negedge CLK);
    check("pre_rst_count", fifo_count, 2);
    #2 RESET_B = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", fifo_count, 0);
    repeat (2) @(negedge CLK);
    RESET_B = 1'b1;
    seen_low = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (tx !== 1'b1 || busy !== 1'b0) seen_low = 1'b1;
    end
    check("post_rst_quiet", seen_low, 1'b0);

    // Stream 12 distinct bytes without overfilling, exercising pointer wrap
    base = 8'($urandom_range(0, 255));
    for (int i = 0; i < 12; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) drive(1'b0, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      t = 0;
      while (m_fifo.size() >= DEPTH && t < 200) begin
        @(negedge CLK);
        t++;
      end
      check("wrap_wait", (t < 200), 1);
      wr_valid = 1'b1;
      wr_data = 8'(base + i * 37);
    end
    drive(1'b0, 8'h00, 1'b0);
    wait_drain(1000);
    check("wrap_no_ovf", overflow, 1'b0);
    check("wrap_count_zero", fifo_count, 0);

    // Random traffic including overflow attempts and clears
    repeat (400) drive(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 7) == 0));
    drive(1'b0, 8'h00, 1'b0);
    wait_drain(1000);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
